// File: rtl/md_defs.sv
// Shared encodings and sizes for the multiply/divide unit.
package md_defs;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int RES_W           = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdState_t;

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div datapath producing {hi,lo} from latched op/operands.
// Zero latency; no flow control (purely combinational).
// Divide-by-zero is flagged so the caller can leave HI/LO untouched.
module md_arith
    import md_defs::*;
(
    input  logic [3:0]       op,
    input  logic [31:0]      opA,
    input  logic [31:0]      opB,
    output logic [RES_W-1:0] result,
    output logic             divByZero
);

    logic [63:0] sProd;
    logic [63:0] uProd;
    logic [31:0] safeB;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [31:0] magQ;
    logic [31:0] magR;
    logic [31:0] sQuot;
    logic [31:0] sRem;
    logic [31:0] uQuot;
    logic [31:0] uRem;

    // Sign-extended 64x64 multiply keeps the low 64 bits exact for signed operands.
    assign sProd = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};
    assign uProd = {32'd0, opA} * {32'd0, opB};

    // Divisor forced nonzero so the dividers never see zero; result is discarded then.
    assign safeB = (opB == 32'd0) ? 32'd1 : opB;
    assign absA  = opA[31] ? (~opA + 32'd1) : opA;
    assign absB  = safeB[31] ? (~safeB + 32'd1) : safeB;
    assign magQ  = absA / absB;
    assign magR  = absA % absB;
    assign sQuot = (opA[31] ^ safeB[31]) ? (~magQ + 32'd1) : magQ;
    assign sRem  = opA[31] ? (~magR + 32'd1) : magR;
    assign uQuot = opA / safeB;
    assign uRem  = opA % safeB;

    always_comb begin
        result    = '0;
        divByZero = 1'b0;
        unique case (op)
            MD_MULT:  result = sProd;
            MD_MULTU: result = uProd;
            MD_DIV: begin
                result    = {sRem, sQuot};
                divByZero = (opB == 32'd0);
            end
            MD_DIVU: begin
                result    = {uRem, uQuot};
                divByZero = (opB == 32'd0);
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO, with a fixed-latency busy counter.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles, result visible the cycle after busy falls.
// Backpressure: stall_md holds D-stage HI/LO users while an operation starts or is in flight.
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op_E,
    input  logic [31:0] rs_val_E,
    input  logic [31:0] rt_val_E,
    input  logic        md_use_D,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdState_t         state;
    mdState_t         stateNext;
    logic [CNT_W-1:0] count;
    logic [3:0]       opLatched;
    logic [31:0]      aLatched;
    logic [31:0]      bLatched;
    logic             isMulDiv;
    logic             finishOp;
    logic [RES_W-1:0] arithRes;
    logic             divByZero;

    assign isMulDiv = (md_op_E == MD_MULT) || (md_op_E == MD_MULTU) ||
                      (md_op_E == MD_DIV)  || (md_op_E == MD_DIVU);
    assign start    = isMulDiv && !busy;
    assign stall_md = md_use_D && (start || busy);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            ST_IDLE: if (start)    stateNext = ST_BUSY;
            ST_BUSY: if (finishOp) stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ST_BUSY);
        finishOp = (state == ST_BUSY) && (count == CNT_W'(1));
    end

    md_arith uArith (
        .op        (opLatched),
        .opA       (aLatched),
        .opB       (bLatched),
        .result    (arithRes),
        .divByZero (divByZero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            opLatched <= MD_NONE;
            aLatched  <= '0;
            bLatched  <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            if (start) begin
                opLatched <= md_op_E;
                aLatched  <= rs_val_E;
                bLatched  <= rt_val_E;
                count     <= ((md_op_E == MD_MULT) || (md_op_E == MD_MULTU)) ?
                             CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (busy) begin
                count <= count - CNT_W'(1);
            end

            // Completion and moves are exclusive: moves only act while idle.
            if (finishOp) begin
                if (!divByZero) begin
                    hi <= arithRes[63:32];
                    lo <= arithRes[31:0];
                end
            end else if (!busy && md_op_E == MD_MTHI) begin
                hi <= rs_val_E;
            end else if (!busy && md_op_E == MD_MTLO) begin
                lo <= rs_val_E;
            end
        end
    end

endmodule
